// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding memory read, a single-entry output
// register toward decode, redirect squashing and misaligned-fetch faulting.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        fetch_fault
);

   // S_IDLE parks the unit after a faulting instruction until the next redirect.
   typedef enum logic [2:0] {S_REQ, S_WAIT, S_OUT, S_DROP, S_IDLE} state_t;

   state_t      state_reg;
   logic [31:0] fetch_pc_reg;
   logic [31:0] inst_reg;
   logic [31:0] pc_reg;
   logic        req_valid_reg;
   logic        inst_valid_reg;
   logic        fault_reg;

   logic [31:0] target_pc;
   logic        target_ok;
   logic        req_fire;

   always_comb begin
      target_pc = redirect_valid ? redirect_pc : fetch_pc_reg;
   end

   assign target_ok = (target_pc[1:0] == 2'b00);
   assign req_fire  = req_valid_reg && imem_req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_REQ;
         fetch_pc_reg   <= RESET_PC;
         req_valid_reg  <= 1'b0;
         inst_valid_reg <= 1'b0;
         fault_reg      <= 1'b0;
         inst_reg       <= 32'd0;
         pc_reg         <= 32'd0;
      end else begin
         fetch_pc_reg <= target_pc;
         case (state_reg)
            S_REQ: begin
               if (redirect_valid) begin
                  if (req_fire) begin
                     state_reg     <= S_DROP;
                     req_valid_reg <= 1'b0;
                  end else begin
                     req_valid_reg <= target_ok;
                  end
               end else if (req_valid_reg) begin
                  if (imem_req_ready) begin
                     state_reg     <= S_WAIT;
                     req_valid_reg <= 1'b0;
                  end
               end else if (fetch_pc_reg[1:0] != 2'b00) begin
                  // Misaligned target: present a fault without touching memory.
                  state_reg      <= S_OUT;
                  inst_valid_reg <= 1'b1;
                  inst_reg       <= 32'd0;
                  pc_reg         <= fetch_pc_reg;
                  fault_reg      <= 1'b1;
               end else begin
                  req_valid_reg <= 1'b1;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  if (imem_resp_valid) begin
                     state_reg     <= S_REQ;
                     req_valid_reg <= target_ok;
                  end else begin
                     state_reg <= S_DROP;
                  end
               end else if (imem_resp_valid) begin
                  state_reg      <= S_OUT;
                  inst_valid_reg <= 1'b1;
                  inst_reg       <= imem_resp_data;
                  pc_reg         <= fetch_pc_reg;
                  fault_reg      <= imem_resp_err;
               end
            end
            S_OUT: begin
               if (redirect_valid) begin
                  state_reg      <= S_REQ;
                  req_valid_reg  <= target_ok;
                  inst_valid_reg <= 1'b0;
                  fault_reg      <= 1'b0;
               end else if (inst_ready) begin
                  inst_valid_reg <= 1'b0;
                  fault_reg      <= 1'b0;
                  if (fault_reg) begin
                     state_reg <= S_IDLE;
                  end else begin
                     state_reg     <= S_REQ;
                     fetch_pc_reg  <= fetch_pc_reg + 32'd4;
                     req_valid_reg <= 1'b1;
                  end
               end
            end
            S_DROP: begin
               // The response still owed to a squashed request is swallowed here.
               if (imem_resp_valid) begin
                  state_reg     <= S_REQ;
                  req_valid_reg <= target_ok;
               end
            end
            S_IDLE: begin
               if (redirect_valid) begin
                  state_reg     <= S_REQ;
                  req_valid_reg <= target_ok;
               end
            end
            default: begin
               state_reg     <= S_REQ;
               req_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_valid = req_valid_reg;
   assign imem_req_addr  = fetch_pc_reg;
   assign inst_valid     = inst_valid_reg;
   assign inst           = inst_reg;
   assign pc             = pc_reg;
   assign fetch_fault    = fault_reg;

endmodule
